// File: rtl/rx_iq_pkg.sv
// rtl/rx_iq_pkg.sv - shared widths and sample-pair type for the RX I/Q FIFO
package rx_iq_pkg;

   localparam int IQ_DATA_W      = 24;
   localparam int IQ_FIFO_ADDR_W = 4;

   typedef struct packed {
      logic [IQ_DATA_W-1:0] q;
      logic [IQ_DATA_W-1:0] i;
   } iq_pair_t;

endpackage

// File: rtl/rx_iq_fifo_if.sv
// rtl/rx_iq_fifo_if.sv - DDC sample input and MCU bus read side of the RX I/Q FIFO
interface rx_iq_fifo_if #(
   parameter int DATA_W = 24
);

   logic              sample_valid;
   logic [DATA_W-1:0] sample_I;
   logic [DATA_W-1:0] sample_Q;
   logic              IQ_RX_READ_REQ;
   logic              IQ_RX_READ_CLK;
   logic [DATA_W-1:0] RX_I;
   logic [DATA_W-1:0] RX_Q;
   logic              in_empty;

   modport master (
      output sample_valid, sample_I, sample_Q, IQ_RX_READ_REQ, IQ_RX_READ_CLK,
      input  RX_I, RX_Q, in_empty
   );

   modport slave (
      input  sample_valid, sample_I, sample_Q, IQ_RX_READ_REQ, IQ_RX_READ_CLK,
      output RX_I, RX_Q, in_empty
   );

endinterface

// File: rtl/iq_fifo_mem.sv
// rtl/iq_fifo_mem.sv - simple dual-port storage, one write port and one registered read port
module iq_fifo_mem #(
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 48
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Same-cycle read of the slot being written returns the old contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/rx_iq_fifo.sv
// rtl/rx_iq_fifo.sv - show-ahead FIFO between the RX DDC output and the MCU parallel bus
module rx_iq_fifo
   import rx_iq_pkg::*;
#(
   parameter int DATA_W = IQ_DATA_W,
   parameter int ADDR_W = IQ_FIFO_ADDR_W
) (
   input  logic            clk_in,
   input  logic            reset_n,
   rx_iq_fifo_if.slave     bus,
   input  logic            flush,
   input  logic            overrun_clr,
   output logic [ADDR_W:0] level,
   output logic            iq_overrun,
   output logic            iq_underrun
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [ADDR_W:0]     level_next;
   logic                read_clk_d, pop, pop_eff, push;
   logic                in_empty_next, overrun_next, underrun_next;
   logic [2*DATA_W-1:0] head;

   always_comb begin
      pop         = bus.IQ_RX_READ_REQ & bus.IQ_RX_READ_CLK & ~read_clk_d;
      pop_eff     = pop & (level != '0);
      push        = bus.sample_valid & ((level < DEPTH) | pop);
      wr_ptr_next = push    ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr_next = pop_eff ? rd_ptr + ADDR_W'(1) : rd_ptr;
      level_next  = level;
      if (push & ~pop_eff) begin
         level_next = level + (ADDR_W+1)'(1);
      end else if (~push & pop_eff) begin
         level_next = level - (ADDR_W+1)'(1);
      end
      // A head being written this edge is not readable yet, so stay empty one more cycle.
      in_empty_next = (level_next == '0) | (push & (wr_ptr == rd_ptr_next));
      overrun_next  = (bus.sample_valid & ~push) | (iq_overrun & ~overrun_clr);
      underrun_next = (pop & (level == '0)) | (iq_underrun & ~overrun_clr);
      if (flush) begin
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         level_next    = '0;
         in_empty_next = 1'b1;
         overrun_next  = 1'b0;
         underrun_next = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         read_clk_d   <= 1'b0;
         bus.in_empty <= 1'b1;
         iq_overrun   <= 1'b0;
         iq_underrun  <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         level        <= level_next;
         read_clk_d   <= bus.IQ_RX_READ_CLK;
         bus.in_empty <= in_empty_next;
         iq_overrun   <= overrun_next;
         iq_underrun  <= underrun_next;
      end
   end

   iq_fifo_mem #(
      .ADDR_W (ADDR_W),
      .WIDTH  (2*DATA_W)
   ) u_mem (
      .clk     (clk_in),
      .reset_n (reset_n),
      .wr_en   (push & ~flush),
      .wr_addr (wr_ptr),
      .wr_data ({bus.sample_Q, bus.sample_I}),
      .rd_en   (~in_empty_next),
      .rd_clr  (flush),
      .rd_addr (rd_ptr_next),
      .rd_data (head)
   );

   assign bus.RX_I = head[DATA_W-1:0];
   assign bus.RX_Q = head[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_rx_iq_fifo.sv
// tb/tb_rx_iq_fifo.sv - self-checking bench for rx_iq_fifo with a queue reference model
module tb_rx_iq_fifo;
   import rx_iq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       flush = 1'b0;
   logic       overrun_clr = 1'b0;
   logic [4:0] level;
   logic       iq_overrun;
   logic       iq_underrun;

   int tests = 0;
   int fails = 0;

   rx_iq_fifo_if #(.DATA_W(24)) bus ();

   rx_iq_fifo #(.DATA_W(24), .ADDR_W(4)) dut (
      .clk_in      (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .flush       (flush),
      .overrun_clr (overrun_clr),
      .level       (level),
      .iq_overrun  (iq_overrun),
      .iq_underrun (iq_underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   iq_pair_t    m_q[$];
   logic        m_prev_rclk;
   logic        m_ovr;
   logic        m_und;
   logic [23:0] m_last;

   task automatic model_clear();
      m_q.delete();
      m_prev_rclk = 1'b0;
      m_ovr = 1'b0;
      m_und = 1'b0;
      m_last = '0;
   endtask

   // One clock: apply inputs, update the reference model at the edge, return 1 time unit later.
   task automatic step(input logic sv, input logic [23:0] si, input logic [23:0] sq,
                       input logic req, input logic rclk, input logic fl, input logic clr);
      logic pop;
      int   n;
      bus.sample_valid   = sv;
      bus.sample_I       = si;
      bus.sample_Q       = sq;
      bus.IQ_RX_READ_REQ = req;
      bus.IQ_RX_READ_CLK = rclk;
      flush              = fl;
      overrun_clr        = clr;
      @(posedge clk);
      pop = req & rclk & ~m_prev_rclk;
      m_prev_rclk = rclk;
      if (fl) begin
         m_q.delete();
         m_ovr = 1'b0;
         m_und = 1'b0;
      end else begin
         logic set_o, set_u;
         n = m_q.size();
         set_o = 1'b0;
         set_u = pop && (n == 0);
         if (pop && n > 0) begin
            iq_pair_t t;
            t = m_q.pop_front();
            m_last = t.i;
         end
         if (sv) begin
            if (n < 16 || pop) m_q.push_back({sq, si});
            else set_o = 1'b1;
         end
         m_ovr = set_o ? 1'b1 : (clr ? 1'b0 : m_ovr);
         m_und = set_u ? 1'b1 : (clr ? 1'b0 : m_und);
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.sample_valid = 1'b0; bus.sample_I = '0; bus.sample_Q = '0;
      bus.IQ_RX_READ_REQ = 1'b0; bus.IQ_RX_READ_CLK = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d exp 0", level); end
      tests++; if (bus.in_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b exp 1", bus.in_empty); end
      tests++; if (bus.RX_I !== 24'd0 || bus.RX_Q !== 24'd0) begin fails++; $display("FAIL reset_rx: got %h/%h exp 0/0", bus.RX_I, bus.RX_Q); end
      tests++; if (iq_overrun !== 1'b0 || iq_underrun !== 1'b0) begin fails++; $display("FAIL reset_flags: got %b%b exp 00", iq_overrun, iq_underrun); end
   endtask

   task automatic test_first_write();
      step(1'b1, 24'h123456, 24'hFEDCBA, 1'b0, 1'b0, 1'b0, 1'b0);
      tests++; if (bus.in_empty !== 1'b1) begin fails++; $display("FAIL first_empty_early: got %b exp 1", bus.in_empty); end
      tests++; if (level !== 5'd1) begin fails++; $display("FAIL first_level_early: got %0d exp 1", level); end
      idle(1);
      tests++; if (bus.RX_I !== 24'h123456 || bus.RX_Q !== 24'hFEDCBA) begin fails++; $display("FAIL first_rx: got %h/%h exp 123456/fedcba", bus.RX_I, bus.RX_Q); end
      tests++; if (bus.in_empty !== 1'b0) begin fails++; $display("FAIL first_empty: got %b exp 0", bus.in_empty); end
      tests++; if (level !== 5'd1) begin fails++; $display("FAIL first_level: got %0d exp 1", level); end
   endtask

   task automatic test_pop_sequence();
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) step(1'b1, 24'(k), 24'(k + 50), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      for (int k = 1; k <= 3; k++) begin
         tests++; if (bus.RX_I !== 24'(k)) begin fails++; $display("FAIL pop_seq_data: got %0d exp %0d", bus.RX_I, k); end
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
         idle(5);
      end
      tests++; if (bus.in_empty !== 1'b1) begin fails++; $display("FAIL pop_seq_empty: got %b exp 1", bus.in_empty); end
      tests++; if (level !== 5'd0) begin fails++; $display("FAIL pop_seq_level: got %0d exp 0", level); end
      tests++; if (iq_underrun !== 1'b0) begin fails++; $display("FAIL pop_seq_underrun: got %b exp 0", iq_underrun); end
   endtask

   task automatic test_overrun_wrap();
      for (int k = 1; k <= 17; k++) step(1'b1, 24'(k), 24'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      tests++; if (level !== 5'd16) begin fails++; $display("FAIL ovr_level: got %0d exp 16", level); end
      tests++; if (iq_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b exp 1", iq_overrun); end
      for (int k = 1; k <= 16; k++) begin
         tests++; if (bus.RX_I !== 24'(k)) begin fails++; $display("FAIL ovr_wrap_data: got %0d exp %0d", bus.RX_I, k); end
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
         idle(1);
      end
      tests++; if (level !== 5'd0 || bus.in_empty !== 1'b1) begin fails++; $display("FAIL ovr_drain: got level %0d empty %b exp 0/1", level, bus.in_empty); end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (iq_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clr: got %b exp 0", iq_overrun); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 16; k++) step(1'b1, 24'(100 + k), 24'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 24'd999, 24'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (level !== 5'd16) begin fails++; $display("FAIL full_pp_level: got %0d exp 16", level); end
      tests++; if (iq_overrun !== 1'b0) begin fails++; $display("FAIL full_pp_overrun: got %b exp 0", iq_overrun); end
      idle(1);
      for (int k = 0; k < 16; k++) begin
         logic [23:0] exp_i;
         exp_i = (k < 15) ? 24'(101 + k) : 24'd999;
         tests++; if (bus.RX_I !== exp_i) begin fails++; $display("FAIL full_pp_data: got %0d exp %0d", bus.RX_I, exp_i); end
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
         idle(1);
      end
   endtask

   task automatic test_underrun_hold();
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (iq_underrun !== 1'b1) begin fails++; $display("FAIL und_flag: got %b exp 1", iq_underrun); end
      tests++; if (bus.RX_I !== 24'd999) begin fails++; $display("FAIL und_hold: got %0d exp 999", bus.RX_I); end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (iq_underrun !== 1'b0) begin fails++; $display("FAIL und_clr: got %b exp 0", iq_underrun); end
      step(1'b1, 24'd7, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 24'd8, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (level !== 5'd1) begin fails++; $display("FAIL held_clk_level: got %0d exp 1", level); end
      tests++; if (bus.RX_I !== 24'd8) begin fails++; $display("FAIL held_clk_data: got %0d exp 8", bus.RX_I); end
      tests++; if (iq_underrun !== 1'b0) begin fails++; $display("FAIL held_clk_underrun: got %b exp 0", iq_underrun); end
      idle(1);
   endtask

   task automatic test_flush_async_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 24'(20 + k), 24'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      tests++; if (level !== 5'd5) begin fails++; $display("FAIL flush_pre_level: got %0d exp 5", level); end
      step(1'b1, 24'd55, 24'd55, 1'b0, 1'b0, 1'b1, 1'b0);
      tests++; if (level !== 5'd0 || bus.in_empty !== 1'b1) begin fails++; $display("FAIL flush_state: got level %0d empty %b exp 0/1", level, bus.in_empty); end
      tests++; if (bus.RX_I !== 24'd0) begin fails++; $display("FAIL flush_rx: got %h exp 0", bus.RX_I); end
      for (int k = 0; k < 3; k++) step(1'b1, 24'(40 + k), 24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      tests++; if (bus.RX_I !== 24'd40 || level !== 5'd3) begin fails++; $display("FAIL refill: got %0d level %0d exp 40/3", bus.RX_I, level); end
      #3;
      reset_n = 1'b0;
      #1;
      tests++; if (level !== 5'd0 || bus.in_empty !== 1'b1) begin fails++; $display("FAIL async_rst_state: got level %0d empty %b exp 0/1", level, bus.in_empty); end
      tests++; if (bus.RX_I !== 24'd0 || bus.RX_Q !== 24'd0) begin fails++; $display("FAIL async_rst_rx: got %h/%h exp 0/0", bus.RX_I, bus.RX_Q); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
   endtask

   task automatic test_random();
      int sv_pct;
      logic rclk;
      rclk = 1'b0;
      for (int c = 0; c < 600; c++) begin
         sv_pct = (c < 200) ? 70 : ((c < 400) ? 20 : 45);
         rclk = ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 99) < sv_pct, 24'($urandom), 24'($urandom),
              $urandom_range(0, 3) != 0, rclk,
              $urandom_range(0, 127) == 0, $urandom_range(0, 31) == 0);
         tests++; if (level !== 5'(m_q.size())) begin fails++; $display("FAIL rnd_level: cycle %0d got %0d exp %0d", c, level, m_q.size()); end
         tests++; if (iq_overrun !== m_ovr || iq_underrun !== m_und) begin fails++; $display("FAIL rnd_flags: cycle %0d got %b%b exp %b%b", c, iq_overrun, iq_underrun, m_ovr, m_und); end
         if (m_q.size() == 0) begin
            tests++; if (bus.in_empty !== 1'b1) begin fails++; $display("FAIL rnd_empty: cycle %0d got %b exp 1", c, bus.in_empty); end
         end else if (bus.in_empty === 1'b0) begin
            tests++; if (bus.RX_I !== m_q[0].i || bus.RX_Q !== m_q[0].q) begin fails++; $display("FAIL rnd_head: cycle %0d got %h/%h exp %h/%h", c, bus.RX_I, bus.RX_Q, m_q[0].i, m_q[0].q); end
         end
      end
      idle(2);
      tests++; if (bus.in_empty !== (m_q.size() == 0)) begin fails++; $display("FAIL rnd_settle_empty: got %b exp %b", bus.in_empty, m_q.size() == 0); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_first_write();
      test_pop_sequence();
      test_overrun_wrap();
      test_full_push_pop();
      test_underrun_hold();
      test_flush_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
